watch_mode_ctrl: RTL

WATCH_MODE_CTRL -- requirements
Module: watch_mode_ctrl

---
 rtl/watch_mode_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/watch_mode_ctrl.sv
// Two-button watch-setting controller: debounced MODE/INC keys, edit-field selection,
// one-hot increment strobes and idle timeout. Define WATCH_MODE_AUTOREPEAT_EN for held-key repeat.
module watch_mode_ctrl #(
    parameter int CLK_HZ           = 50000000,
    parameter int DEBOUNCE_CYC     = 1000000,
    parameter int IDLE_TIMEOUT_S   = 30,
    parameter int REPEAT_DELAY_CYC = 25000000,
    parameter int REPEAT_RATE_CYC  = 5000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       KEY_MODE_N,
    input  logic       KEY_INC_N,
    output logic [2:0] field_sel,
    output logic [6:0] inc_pulse,
    output logic [1:0] disp_sel,
    output logic [2:0] led_edit
);

    localparam int DB_W     = $clog2(DEBOUNCE_CYC + 1);
    localparam int CYC_W    = $clog2(CLK_HZ + 1);
    localparam int SEC_W    = $clog2(IDLE_TIMEOUT_S + 1);
    localparam int KEY_MODE = 0;
    localparam int KEY_INC  = 1;

    logic [1:0] key_raw;
    logic [1:0] deb_lvl;
    logic [1:0] press;

    assign key_raw = {KEY_INC_N, KEY_MODE_N};

    // Per key: 2-flop synchronizer, run-length debouncer, falling-edge press detect.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            logic            sync1_reg;
            logic            sync2_reg;
            logic            deb_reg;
            logic            deb_prev_reg;
            logic [DB_W-1:0] cnt_reg;

            always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
                if (!RESET_N) begin
                    sync1_reg    <= 1'b1;
                    sync2_reg    <= 1'b1;
                    deb_reg      <= 1'b1;
                    deb_prev_reg <= 1'b1;
                    cnt_reg      <= '0;
                end else begin
                    sync1_reg    <= key_raw[gi];
                    sync2_reg    <= sync1_reg;
                    deb_prev_reg <= deb_reg;
                    if (sync2_reg == deb_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_W'(DEBOUNCE_CYC - 1)) begin
                        deb_reg <= sync2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + DB_W'(1);
                    end
                end
            end

            assign deb_lvl[gi] = deb_reg;
            assign press[gi]   = deb_prev_reg & ~deb_reg;
        end
    endgenerate

    logic             mode_press;
    logic             inc_press;
    logic             inc_held;
    logic             rep_fire;

    assign mode_press = press[KEY_MODE];
    assign inc_press  = press[KEY_INC];
    assign inc_held   = ~deb_lvl[KEY_INC];

`ifdef WATCH_MODE_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic             rep_active_reg, rep_active_next;
    logic             rep_first_reg, rep_first_next;
    logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;
    logic [REP_W-1:0] rep_limit;

    // First repeat waits the long delay; later ones use the shorter rate.
    always_comb begin
        rep_limit       = rep_first_reg ? REP_W'(REPEAT_DELAY_CYC - 1) : REP_W'(REPEAT_RATE_CYC - 1);
        rep_fire        = rep_active_reg & inc_held & (rep_cnt_reg == rep_limit);
        rep_active_next = rep_active_reg;
        rep_first_next  = rep_first_reg;
        rep_cnt_next    = rep_cnt_reg;
        if (!inc_held || mode_press) begin
            rep_active_next = 1'b0;
            rep_cnt_next    = '0;
        end else if (inc_press) begin
            rep_active_next = 1'b1;
            rep_first_next  = 1'b1;
            rep_cnt_next    = '0;
        end else if (rep_active_reg) begin
            if (rep_fire) begin
                rep_first_next = 1'b0;
                rep_cnt_next   = '0;
            end else begin
                rep_cnt_next = rep_cnt_reg + REP_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            rep_active_reg <= 1'b0;
            rep_first_reg  <= 1'b1;
            rep_cnt_reg    <= '0;
        end else begin
            rep_active_reg <= rep_active_next;
            rep_first_reg  <= rep_first_next;
            rep_cnt_reg    <= rep_cnt_next;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    logic [2:0]       field_sel_reg, field_sel_next;
    logic [6:0]       inc_pulse_reg, inc_pulse_next;
    logic [1:0]       disp_sel_reg, disp_sel_next;
    logic [CYC_W-1:0] cyc_cnt_reg, cyc_cnt_next;
    logic [SEC_W-1:0] sec_cnt_reg, sec_cnt_next;
    logic             activity;

    always_comb begin
        field_sel_next = field_sel_reg;
        inc_pulse_next = '0;
        cyc_cnt_next   = cyc_cnt_reg;
        sec_cnt_next   = sec_cnt_reg;
        disp_sel_next  = 2'd0;
        activity       = 1'b0;

        // Mode wins over a coincident inc press or repeat; the inc event is dropped.
        if (mode_press) begin
            field_sel_next = (field_sel_reg >= 3'd6) ? 3'd0 : field_sel_reg + 3'd1;
            activity       = 1'b1;
        end else if (inc_press || rep_fire) begin
            inc_pulse_next = 7'd1 << field_sel_reg;
            activity       = 1'b1;
        end

        if (activity || field_sel_reg == 3'd0) begin
            cyc_cnt_next = '0;
            sec_cnt_next = '0;
        end else if (sec_cnt_reg == SEC_W'(IDLE_TIMEOUT_S)) begin
            field_sel_next = 3'd0;
            cyc_cnt_next   = '0;
            sec_cnt_next   = '0;
        end else if (cyc_cnt_reg == CYC_W'(CLK_HZ - 1)) begin
            // Reaching the limit is caught by the branch above, so this never wraps.
            cyc_cnt_next = '0;
            sec_cnt_next = sec_cnt_reg + SEC_W'(1);
        end else begin
            cyc_cnt_next = cyc_cnt_reg + CYC_W'(1);
        end

        case (field_sel_next)
            3'd0, 3'd1, 3'd2: disp_sel_next = 2'd0;
            3'd3, 3'd4, 3'd5: disp_sel_next = 2'd1;
            3'd6:             disp_sel_next = 2'd2;
            default:          disp_sel_next = 2'd0;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            field_sel_reg <= 3'd0;
            inc_pulse_reg <= '0;
            disp_sel_reg  <= 2'd0;
            cyc_cnt_reg   <= '0;
            sec_cnt_reg   <= '0;
        end else begin
            field_sel_reg <= field_sel_next;
            inc_pulse_reg <= inc_pulse_next;
            disp_sel_reg  <= disp_sel_next;
            cyc_cnt_reg   <= cyc_cnt_next;
            sec_cnt_reg   <= sec_cnt_next;
        end
    end

    // Digit indicator within the current page, lit only while INC is held.
    always_comb begin
        led_edit = 3'b000;
        if (inc_held) begin
            case (field_sel_reg)
                3'd0, 3'd3: led_edit = 3'b001;
                3'd1, 3'd4: led_edit = 3'b010;
                3'd2, 3'd5: led_edit = 3'b100;
                default:    led_edit = 3'b000;
            endcase
        end
    end

    assign field_sel = field_sel_reg;
    assign inc_pulse = inc_pulse_reg;
    assign disp_sel  = disp_sel_reg;

endmodule
